// File: rtl/maze_pkg.sv
// Shared types and helpers for the maze solver output path.
// Location layout: row in the upper nibble, column in the lower nibble.
package maze_pkg;

    localparam int LOC_W = 8;
    localparam int ROW_W = 4;
    localparam int COL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PLAY    = 2'd2,
        ST_FINISH  = 2'd3
    } state_e;

    function automatic logic [ROW_W-1:0] loc_row(input logic [LOC_W-1:0] l);
        return l[LOC_W-1 -: ROW_W];
    endfunction

    function automatic logic [COL_W-1:0] loc_col(input logic [LOC_W-1:0] l);
        return l[COL_W-1:0];
    endfunction

    // True when a and b are exactly one row or one column step apart.
    function automatic logic loc_adjacent(input logic [LOC_W-1:0] a,
                                          input logic [LOC_W-1:0] b);
        logic [ROW_W-1:0] ra, rb, dr;
        logic [COL_W-1:0] ca, cb, dc;
        ra = loc_row(a);
        rb = loc_row(b);
        ca = loc_col(a);
        cb = loc_col(b);
        dr = (ra > rb) ? ra - rb : rb - ra;
        dc = (ca > cb) ? ca - cb : cb - ca;
        return ({1'b0, dr} + {1'b0, dc}) == 5'd1;
    endfunction

endpackage

// File: rtl/path_buf.sv
// Location buffer: synchronous write, asynchronous read, no reset.
module path_buf #(
    parameter int DEPTH = 256,
    parameter int LOC_W = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [LOC_W-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [LOC_W-1:0] rdata_o
);

    logic [LOC_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/path_player.sv
// Captures popped stack entries and replays them start-to-destination.
// Optional adjacency checker enabled by defining PATH_ADJ_CHECK_EN.
module path_player #(
    parameter int DEPTH = 256,
    parameter int LOC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             done,
    input  logic             pop,
    input  logic             empStck,
    input  logic [LOC_W-1:0] stckTop,
    input  logic             outRdy,
    output logic             outVld,
    output logic [LOC_W-1:0] outLoc,
    output logic             pathDone,
    output logic             busy,
    output logic             ovf,
    output logic             badStep
);

    import maze_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic             ovf_q, ovf_d;
    logic             outVld_q, pathDone_q, busy_q;
    logic             wr_en;
    logic             xfer;
    logic [LOC_W-1:0] rd_data;

    assign xfer = outVld_q && outRdy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdPtr_d = rdPtr_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (done) begin
                    state_d = ST_COLLECT;
                    ovf_d   = 1'b0;
                end
            end
            ST_COLLECT: begin
                // Stack empty wins over a coincident pop.
                if (empStck) begin
                    if (cnt_q == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_PLAY;
                        rdPtr_d = cnt_q[AW-1:0] - AW'(1);
                    end
                end else if (pop) begin
                    if (cnt_q < FULL) begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (xfer) begin
                    if (rdPtr_q == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        rdPtr_d = rdPtr_q - AW'(1);
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rdPtr_q    <= '0;
            ovf_q      <= 1'b0;
            outVld_q   <= 1'b0;
            pathDone_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdPtr_q    <= rdPtr_d;
            ovf_q      <= ovf_d;
            outVld_q   <= (state_d == ST_PLAY);
            pathDone_q <= (state_d == ST_FINISH);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    path_buf #(
        .DEPTH (DEPTH),
        .LOC_W (LOC_W),
        .AW    (AW)
    ) u_buf (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (cnt_q[AW-1:0]),
        .wdata_i (stckTop),
        .raddr_i (rdPtr_q),
        .rdata_o (rd_data)
    );

    assign outVld   = outVld_q;
    assign outLoc   = outVld_q ? rd_data : '0;
    assign pathDone = pathDone_q;
    assign busy     = busy_q;
    assign ovf      = ovf_q;

`ifdef PATH_ADJ_CHECK_EN
    logic [LOC_W-1:0] prev_q;
    logic             havePrev_q;
    logic             badStep_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= '0;
            havePrev_q <= 1'b0;
            badStep_q  <= 1'b0;
        end else if (state_q == ST_IDLE && done) begin
            havePrev_q <= 1'b0;
            badStep_q  <= 1'b0;
        end else if (xfer) begin
            if (havePrev_q && !loc_adjacent(prev_q, outLoc)) begin
                badStep_q <= 1'b1;
            end
            prev_q     <= outLoc;
            havePrev_q <= 1'b1;
        end
    end

    assign badStep = badStep_q;
`else
    assign badStep = 1'b0;
`endif

endmodule

// File: tb/tb_path_player.sv
// Directed bench for path_player: a DEPTH=256 instance and a DEPTH=4
// instance share all inputs; the small one exercises overflow.
module tb_path_player;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       done = 1'b0;
    logic       pop = 1'b0;
    logic       empStck = 1'b0;
    logic [7:0] stckTop = 8'h00;
    logic       outRdy = 1'b0;

    logic       outVld, pathDone, busy, ovf, badStep;
    logic [7:0] outLoc;
    logic       s_outVld, s_pathDone, s_busy, s_ovf, s_badStep;
    logic [7:0] s_outLoc;

    int errors = 0;
    int checks = 0;

`ifdef PATH_ADJ_CHECK_EN
    localparam logic ADJ_EXP = 1'b1;
`else
    localparam logic ADJ_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    path_player #(.DEPTH(256), .LOC_W(8)) u_dut (
        .clk(clk), .rst(rst), .done(done), .pop(pop),
        .empStck(empStck), .stckTop(stckTop), .outRdy(outRdy),
        .outVld(outVld), .outLoc(outLoc), .pathDone(pathDone),
        .busy(busy), .ovf(ovf), .badStep(badStep)
    );

    path_player #(.DEPTH(4), .LOC_W(8)) u_small (
        .clk(clk), .rst(rst), .done(done), .pop(pop),
        .empStck(empStck), .stckTop(stckTop), .outRdy(outRdy),
        .outVld(s_outVld), .outLoc(s_outLoc), .pathDone(s_pathDone),
        .busy(s_busy), .ovf(s_ovf), .badStep(s_badStep)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle after empStck was sampled.
    task automatic collect(input logic [7:0] locs[$]);
        done = 1'b1;
        tick();
        done = 1'b0;
        foreach (locs[i]) begin
            pop = 1'b1;
            stckTop = locs[i];
            tick();
        end
        pop = 1'b0;
        empStck = 1'b1;
        tick();
        empStck = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({outVld, pathDone, busy, ovf, badStep} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {outVld, pathDone, busy, ovf, badStep});
        end
        checks++;
        if (outLoc !== 8'h00) begin
            errors++;
            $display("FAIL reset_loc: got %h want 00", outLoc);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] q[$];
        q = {8'h02, 8'h01, 8'h00};
        outRdy = 1'b1;
        collect(q);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (outVld !== 1'b1 || outLoc !== 8'(i)) begin
                errors++;
                $display("FAIL basic_out[%0d]: got vld=%b loc=%h want vld=1 loc=%h",
                         i, outVld, outLoc, 8'(i));
            end
            tick();
        end
        checks++;
        if (pathDone !== 1'b1 || outVld !== 1'b0) begin
            errors++;
            $display("FAIL basic_pathDone: got pd=%b vld=%b want pd=1 vld=0",
                     pathDone, outVld);
        end
        checks++;
        if (badStep !== 1'b0) begin
            errors++;
            $display("FAIL basic_badStep: got %b want 0", badStep);
        end
        tick();
        checks++;
        if (pathDone !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: got pd=%b busy=%b want 0 0", pathDone, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] q[$];
        q = {8'h02, 8'h01, 8'h00};
        outRdy = 1'b0;
        collect(q);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (outVld !== 1'b1 || outLoc !== 8'h00) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got vld=%b loc=%h want vld=1 loc=00",
                         i, outVld, outLoc);
            end
            tick();
        end
        outRdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (outVld !== 1'b1 || outLoc !== 8'(i)) begin
                errors++;
                $display("FAIL bp_out[%0d]: got vld=%b loc=%h want vld=1 loc=%h",
                         i, outVld, outLoc, 8'(i));
            end
            tick();
        end
        checks++;
        if (pathDone !== 1'b1) begin
            errors++;
            $display("FAIL bp_pathDone: got %b want 1", pathDone);
        end
        tick();
    endtask

    task automatic test_empty();
        int pulses = 0;
        int vlds = 0;
        done = 1'b1;
        tick();
        done = 1'b0;
        empStck = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (outVld) vlds++;
            if (pathDone) begin
                pulses++;
                checks++;
                if (i !== 1) begin
                    errors++;
                    $display("FAIL empty_timing: got cycle %0d want cycle 1", i);
                end
            end
            tick();
            empStck = 1'b0;
        end
        checks++;
        if (vlds !== 0 || pulses !== 1) begin
            errors++;
            $display("FAIL empty_path: got vld_cycles=%0d pulses=%0d want 0 1",
                     vlds, pulses);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] q[$];
        q = {8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        outRdy = 1'b1;
        collect(q);
        checks++;
        if (s_ovf !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_flag: got small=%b big=%b want 1 0", s_ovf, ovf);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (outLoc !== 8'(i)) begin
                errors++;
                $display("FAIL ovf_big[%0d]: got %h want %h", i, outLoc, 8'(i));
            end
            if (i < 4) begin
                checks++;
                if (s_outVld !== 1'b1 || s_outLoc !== 8'(i + 2)) begin
                    errors++;
                    $display("FAIL ovf_small[%0d]: got vld=%b loc=%h want vld=1 loc=%h",
                             i, s_outVld, s_outLoc, 8'(i + 2));
                end
            end
            if (i == 4) begin
                checks++;
                if (s_pathDone !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_small_pd: got %b want 1", s_pathDone);
                end
            end
            tick();
        end
        checks++;
        if (pathDone !== 1'b1 || s_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_end: got pd=%b small_ovf=%b want 1 1", pathDone, s_ovf);
        end
        tick();
    endtask

    task automatic test_adjacency();
        logic [7:0] q[$];
        q = {8'h22, 8'h00};
        outRdy = 1'b1;
        collect(q);
        tick();
        checks++;
        if (badStep !== 1'b0) begin
            errors++;
            $display("FAIL adj_first: got %b want 0", badStep);
        end
        tick();
        checks++;
        if (badStep !== ADJ_EXP || pathDone !== 1'b1) begin
            errors++;
            $display("FAIL adj_badStep: got bs=%b pd=%b want bs=%b pd=1",
                     badStep, pathDone, ADJ_EXP);
        end
        tick();
    endtask

    task automatic test_reset_mid_play();
        logic [7:0] q[$];
        q = {8'h02, 8'h01, 8'h00};
        outRdy = 1'b1;
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (badStep !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL collect_clear: got bs=%b busy=%b want 0 1", badStep, busy);
        end
        foreach (q[i]) begin
            pop = 1'b1;
            stckTop = q[i];
            tick();
        end
        pop = 1'b0;
        empStck = 1'b1;
        tick();
        empStck = 1'b0;
        tick();
        checks++;
        if (outVld !== 1'b1 || outLoc !== 8'h01) begin
            errors++;
            $display("FAIL rst_pre: got vld=%b loc=%h want 1 01", outVld, outLoc);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({outVld, pathDone, busy, ovf, badStep} !== 5'b0 || outLoc !== 8'h00) begin
            errors++;
            $display("FAIL rst_async: got flags=%b loc=%h want 00000 00",
                     {outVld, pathDone, busy, ovf, badStep}, outLoc);
        end
        tick();
        rst = 1'b0;
        tick();
        q = {8'h11, 8'h10};
        collect(q);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (outVld !== 1'b1 || outLoc !== 8'(8'h10 + i)) begin
                errors++;
                $display("FAIL rst_rerun[%0d]: got vld=%b loc=%h want vld=1 loc=%h",
                         i, outVld, outLoc, 8'(8'h10 + i));
            end
            tick();
        end
        checks++;
        if (pathDone !== 1'b1 || badStep !== 1'b0) begin
            errors++;
            $display("FAIL rst_rerun_end: got pd=%b bs=%b want 1 0", pathDone, badStep);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty();
        test_overflow();
        test_adjacency();
        test_reset_mid_play();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
